// File: rtl/neuron_vmem_update_pkg.sv
// neuron_vmem_update_pkg
//   Shared widths, Q-format helpers and saturation limits for the membrane
//   potential integrator. Fixed-point words are signed Q(INTEGER_WIDTH).(FRAC).
package neuron_vmem_update_pkg;

  localparam int INTEGER_WIDTH   = 32;
  localparam int DATA_WIDTH_FRAC = 32;
  localparam int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC;
  localparam int DELTAT_WIDTH    = 4;
  localparam int REFRAC_WIDTH    = 8;
  localparam int NEURON_ID_WIDTH = 11;

  typedef logic [DATA_WIDTH-1:0] q_t;

  localparam q_t Q_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam q_t Q_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Per-neuron values that ride along the pipe untouched until the decision.
  typedef struct packed {
    logic [NEURON_ID_WIDTH-1:0] id;
    q_t                         vmem;
    q_t                         vthreshold;
    q_t                         vreset;
    logic [REFRAC_WIDTH-1:0]    refrac_in;
    logic [REFRAC_WIDTH-1:0]    refrac_period;
  } nrn_ctx_t;

  function automatic logic [DATA_WIDTH:0] sext1(q_t x);
    return {x[DATA_WIDTH-1], x};
  endfunction

  function automatic logic [DATA_WIDTH+1:0] sext2(q_t x);
    return {{2{x[DATA_WIDTH-1]}}, x};
  endfunction

  // Integer value padded with a zero fraction.
  function automatic q_t int_to_q(logic [INTEGER_WIDTH-1:0] i);
    return {i, {DATA_WIDTH_FRAC{1'b0}}};
  endfunction

  // DeltaT code occupies the top fraction bits; it is always non-negative.
  function automatic q_t deltat_ext(logic [DELTAT_WIDTH-1:0] dt);
    return {{INTEGER_WIDTH{1'b0}}, dt, {(DATA_WIDTH_FRAC-DELTAT_WIDTH){1'b0}}};
  endfunction

  // Clamp a sum carrying two guard bits back into the Q word range.
  function automatic q_t sat_q(logic [DATA_WIDTH+1:0] v);
    if (v[DATA_WIDTH+1:DATA_WIDTH-1] == 3'b000 || v[DATA_WIDTH+1:DATA_WIDTH-1] == 3'b111)
      return v[DATA_WIDTH-1:0];
    else if (v[DATA_WIDTH+1])
      return Q_MIN;
    else
      return Q_MAX;
  endfunction

endpackage

// File: rtl/neuron_vmem_update_fixed_point_mult.sv
// neuron_vmem_update_fixed_point_mult
//   Signed Q-format multiply: full 2*DATA_WIDTH product, re-aligned by taking
//   bits [DATA_WIDTH+FRAC-1:FRAC] (arithmetic truncation toward -inf, no
//   rounding, upper bits wrap). Optional output register.
//   clk, rst_n : clock / async active-low reset (used only when REG_OUT=1)
//   en         : output register load enable
//   a, b       : signed Q operands
//   p          : re-aligned signed Q product
module neuron_vmem_update_fixed_point_mult
  import neuron_vmem_update_pkg::*;
#(
  parameter bit REG_OUT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] p
);

  logic [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]   p_comb;
  logic                    unused_bits;

  assign prod = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a})
              * $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
  assign p_comb = prod[DATA_WIDTH+DATA_WIDTH_FRAC-1:DATA_WIDTH_FRAC];
  assign unused_bits = ^{prod[2*DATA_WIDTH-1:DATA_WIDTH+DATA_WIDTH_FRAC],
                         prod[DATA_WIDTH_FRAC-1:0]};

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  p <= '0;
        else if (en) p <= p_comb;
      end
    end else begin : g_comb
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst_n, en};
      assign p = p_comb;
    end
  endgenerate

endmodule

// File: rtl/neuron_vmem_update.sv
// neuron_vmem_update
//   Three-stage membrane potential integrator with valid/ready flow control.
//   S1: D = vrest - vmem, I = ipsc_ex + ipsc_in (one guard bit)
//   S2: L1 = D * DeltaT
//   S3: L = L1 * TaumemRecip, Vsum = sat(vmem + L + I), refractory/threshold
//       decision; S3 registers drive the outputs.
//   Ports:
//     clk, rst_n                   clock, async active-low reset
//     in_valid / in_ready          input handshake (in_ready comb. from out_ready)
//     neuron_id, vmem, vrest, vthreshold, vreset, ipsc_ex, ipsc_in,
//     taumem_recip, delta_t, refrac_in, refrac_period   input beat
//     out_valid / out_ready        output handshake
//     neuron_id_out, vmem_out, refrac_out, spike_out   result beat
module neuron_vmem_update
  import neuron_vmem_update_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NEURON_ID_WIDTH-1:0] neuron_id,
  input  logic [DATA_WIDTH-1:0]      vmem,
  input  logic [DATA_WIDTH-1:0]      vrest,
  input  logic [DATA_WIDTH-1:0]      vthreshold,
  input  logic [DATA_WIDTH-1:0]      vreset,
  input  logic [DATA_WIDTH-1:0]      ipsc_ex,
  input  logic [DATA_WIDTH-1:0]      ipsc_in,
  input  logic [DATA_WIDTH-1:0]      taumem_recip,
  input  logic [DELTAT_WIDTH-1:0]    delta_t,
  input  logic [REFRAC_WIDTH-1:0]    refrac_in,
  input  logic [REFRAC_WIDTH-1:0]    refrac_period,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NEURON_ID_WIDTH-1:0] neuron_id_out,
  output logic [DATA_WIDTH-1:0]      vmem_out,
  output logic [REFRAC_WIDTH-1:0]    refrac_out,
  output logic                       spike_out
);

  logic s1_valid, s2_valid, s3_valid;
  logic s1_ready, s2_ready, s3_ready;
  logic s1_load, s2_load, s3_load;

  nrn_ctx_t                 s1_ctx, s2_ctx;
  q_t                       s1_d, s1_tau, s2_l1, s2_tau;
  logic [DATA_WIDTH:0]      s1_i, s2_i;
  logic [DELTAT_WIDTH-1:0]  s1_dt;

  q_t                       l1_next, l_next, vsum_sat;
  logic [DATA_WIDTH+1:0]    vsum;
  q_t                       dec_vmem;
  logic [REFRAC_WIDTH-1:0]  dec_refrac;
  logic                     dec_spike;

  // A stage may load when empty or when its contents leave this cycle, so a
  // full pipe with out_ready=1 streams without bubbles.
  assign s3_ready = !s3_valid || out_ready;
  assign s2_ready = !s2_valid || s3_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;

  assign s1_load = in_valid && s1_ready;
  assign s2_load = s1_valid && s2_ready;
  assign s3_load = s2_valid && s3_ready;

  assign out_valid = s3_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (s1_ready) s1_valid <= in_valid;
      if (s2_ready) s2_valid <= s1_valid;
      if (s3_ready) s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ctx <= '0;
      s1_d   <= '0;
      s1_i   <= '0;
      s1_tau <= '0;
      s1_dt  <= '0;
    end else if (s1_load) begin
      s1_ctx <= '{id: neuron_id, vmem: vmem, vthreshold: vthreshold, vreset: vreset,
                  refrac_in: refrac_in, refrac_period: refrac_period};
      s1_d   <= vrest - vmem;
      s1_i   <= sext1(ipsc_ex) + sext1(ipsc_in);
      s1_tau <= taumem_recip;
      s1_dt  <= delta_t;
    end
  end

  neuron_vmem_update_fixed_point_mult #(.REG_OUT(1'b0)) u_mult_dt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (s2_load),
    .a     (s1_d),
    .b     (deltat_ext(s1_dt)),
    .p     (l1_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_ctx <= '0;
      s2_l1  <= '0;
      s2_i   <= '0;
      s2_tau <= '0;
    end else if (s2_load) begin
      s2_ctx <= s1_ctx;
      s2_l1  <= l1_next;
      s2_i   <= s1_i;
      s2_tau <= s1_tau;
    end
  end

  neuron_vmem_update_fixed_point_mult #(.REG_OUT(1'b0)) u_mult_tau (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (s3_load),
    .a     (s2_l1),
    .b     (s2_tau),
    .p     (l_next)
  );

  // Two guard bits cover the worst case of three full-scale terms.
  assign vsum     = sext2(s2_ctx.vmem) + sext2(l_next) + {s2_i[DATA_WIDTH], s2_i};
  assign vsum_sat = sat_q(vsum);

  always_comb begin
    dec_vmem   = vsum_sat;
    dec_refrac = '0;
    dec_spike  = 1'b0;
    if (s2_ctx.refrac_in != '0) begin
      dec_vmem   = s2_ctx.vreset;
      dec_refrac = s2_ctx.refrac_in - 1'b1;
    end else if ($signed(vsum_sat) >= $signed(s2_ctx.vthreshold)) begin
      dec_vmem   = s2_ctx.vreset;
      dec_refrac = s2_ctx.refrac_period;
      dec_spike  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neuron_id_out <= '0;
      vmem_out      <= '0;
      refrac_out    <= '0;
      spike_out     <= 1'b0;
    end else if (s3_load) begin
      neuron_id_out <= s2_ctx.id;
      vmem_out      <= dec_vmem;
      refrac_out    <= dec_refrac;
      spike_out     <= dec_spike;
    end
  end

endmodule

// File: tb/tb_neuron_vmem_update.sv
module tb_neuron_vmem_update;

  typedef struct packed {
    logic [10:0] id;
    logic [63:0] vmem, vrest, vthr, vreset, ex, inh, tau;
    logic [3:0]  dt;
    logic [7:0]  rin, rper;
  } beat_t;

  typedef struct packed {
    logic [10:0] id;
    logic [63:0] vmem;
    logic [7:0]  refrac;
    logic        spike;
  } res_t;

  localparam logic signed [63:0] MAXV = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [63:0] MINV = -64'sh7FFF_FFFF_FFFF_FFFF - 64'sd1;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, spike_out;
  logic [10:0] neuron_id = '0, neuron_id_out;
  logic [63:0] vmem = '0, vrest = '0, vthreshold = '0, vreset = '0;
  logic [63:0] ipsc_ex = '0, ipsc_in = '0, taumem_recip = '0, vmem_out;
  logic [3:0]  delta_t = '0;
  logic [7:0]  refrac_in = '0, refrac_period = '0, refrac_out;

  neuron_vmem_update dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .neuron_id(neuron_id), .vmem(vmem), .vrest(vrest), .vthreshold(vthreshold),
    .vreset(vreset), .ipsc_ex(ipsc_ex), .ipsc_in(ipsc_in), .taumem_recip(taumem_recip),
    .delta_t(delta_t), .refrac_in(refrac_in), .refrac_period(refrac_period),
    .out_valid(out_valid), .out_ready(out_ready), .neuron_id_out(neuron_id_out),
    .vmem_out(vmem_out), .refrac_out(refrac_out), .spike_out(spike_out)
  );

  always #5 clk = ~clk;

  int    n_checks = 0, n_fail = 0;
  int    cyc = 0, occ = 0;
  res_t  exp_q[$];
  int    acc_q[$];
  beat_t cur;
  logic  acc_now, got_out;
  res_t  last_res;
  int    last_lat;
  logic  stall_held;
  res_t  held;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic logic [63:0] qq(int quarters);
    longint t;
    t = longint'(quarters);
    return 64'(t <<< 30);
  endfunction

  // Reference: plain signed arithmetic from the update rules.
  function automatic res_t model(beat_t b);
    res_t r;
    logic signed [63:0]  vm, d, dtx, l1, l, vsat;
    logic signed [127:0] p;
    logic signed [66:0]  vs;
    vm  = b.vmem;
    d   = $signed(b.vrest) - vm;
    dtx = 64'(b.dt) * 64'sd268435456;          // code * 2^28
    p   = 128'(d) * 128'(dtx);
    l1  = 64'(p >>> 32);
    p   = 128'(l1) * 128'($signed(b.tau));
    l   = 64'(p >>> 32);
    vs  = 67'(vm) + 67'(l) + 67'($signed(b.ex)) + 67'($signed(b.inh));
    if (vs > 67'(MAXV))      vsat = MAXV;
    else if (vs < 67'(MINV)) vsat = MINV;
    else                     vsat = 64'(vs);
    r.id = b.id;
    if (b.rin != 0) begin
      r.vmem = b.vreset; r.refrac = b.rin - 8'd1; r.spike = 1'b0;
    end else if (vsat >= $signed(b.vthr)) begin
      r.vmem = b.vreset; r.refrac = b.rper; r.spike = 1'b1;
    end else begin
      r.vmem = vsat; r.refrac = 8'd0; r.spike = 1'b0;
    end
    return r;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.id     = 11'($urandom);
    b.vrest  = qq(-280 + int'($urandom_range(0, 60)));
    b.vmem   = qq(-300 + int'($urandom_range(0, 120))) + {34'b0, 30'($urandom)};
    b.vthr   = qq(-220 + int'($urandom_range(0, 40)));
    b.vreset = qq(-260 + int'($urandom_range(0, 20)));
    b.ex     = qq(int'($urandom_range(0, 40))) + {34'b0, 30'($urandom)};
    b.inh    = qq(-int'($urandom_range(0, 40))) - {34'b0, 30'($urandom)};
    b.tau    = {32'b0, 32'($urandom)};
    b.dt     = 4'($urandom);
    b.rin    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
    b.rper   = 8'($urandom);
    if ($urandom_range(0, 7) == 0) begin
      b.vmem  = {$urandom, $urandom};
      b.vrest = {$urandom, $urandom};
      b.ex    = {$urandom, $urandom};
      b.inh   = {$urandom, $urandom};
      b.tau   = {$urandom, $urandom};
    end
    return b;
  endfunction

  task automatic drive(beat_t b);
    neuron_id = b.id; vmem = b.vmem; vrest = b.vrest; vthreshold = b.vthr;
    vreset = b.vreset; ipsc_ex = b.ex; ipsc_in = b.inh; taumem_recip = b.tau;
    delta_t = b.dt; refrac_in = b.rin; refrac_period = b.rper;
  endtask

  // Called at a negedge with inputs already driven; observes the handshakes
  // that the next posedge will complete.
  task automatic cycle();
    res_t e;
    #1;
    acc_now = 1'b0;
    check_eq("in_ready", 64'(in_ready), 64'((occ == 3 && !out_ready) ? 0 : 1));
    if (stall_held) begin
      check_eq("hold_valid", 64'(out_valid), 64'(1));
      check_eq("hold_vmem", vmem_out, held.vmem);
      check_eq("hold_refrac", 64'(refrac_out), 64'(held.refrac));
      check_eq("hold_spike", 64'(spike_out), 64'(held.spike));
      check_eq("hold_id", 64'(neuron_id_out), 64'(held.id));
    end
    if (out_valid && exp_q.size() == 0)
      check_eq("spurious_out", 64'(out_valid), 64'(0));
    if (out_valid && out_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("out_id", 64'(neuron_id_out), 64'(e.id));
      check_eq("out_vmem", vmem_out, e.vmem);
      check_eq("out_refrac", 64'(refrac_out), 64'(e.refrac));
      check_eq("out_spike", 64'(spike_out), 64'(e.spike));
      last_res = '{id: neuron_id_out, vmem: vmem_out, refrac: refrac_out, spike: spike_out};
      last_lat = cyc - acc_q.pop_front();
      got_out  = 1'b1;
      occ--;
    end
    stall_held = out_valid && !out_ready;
    held = '{id: neuron_id_out, vmem: vmem_out, refrac: refrac_out, spike: spike_out};
    if (in_valid && in_ready) begin
      exp_q.push_back(model(cur));
      acc_q.push_back(cyc);
      occ++;
      acc_now = 1'b1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_directed(string tag, beat_t b, logic [63:0] ev, logic [7:0] er, logic es);
    int n;
    logic accepted;
    cur = b; drive(b);
    in_valid = 1'b1; out_ready = 1'b1;
    got_out = 1'b0; accepted = 1'b0; n = 0;
    while (!accepted && n < 20) begin cycle(); accepted = acc_now; n++; end
    in_valid = 1'b0;
    while (!got_out && n < 40) begin cycle(); n++; end
    check_eq({tag, "_done"}, 64'(got_out), 64'(1));
    if (got_out) begin
      check_eq({tag, "_vmem"}, last_res.vmem, ev);
      check_eq({tag, "_refrac"}, 64'(last_res.refrac), 64'(er));
      check_eq({tag, "_spike"}, 64'(last_res.spike), 64'(es));
      check_eq({tag, "_latency"}, 64'(last_lat), 64'(3));
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check_eq({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    check_eq({tag, "_vmem"}, vmem_out, 64'(0));
    check_eq({tag, "_refrac"}, 64'(refrac_out), 64'(0));
    check_eq({tag, "_spike"}, 64'(spike_out), 64'(0));
    check_eq({tag, "_id"}, 64'(neuron_id_out), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    beat_t b;
    int sent;
    stall_held = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    b = '{id: 11'd7, vmem: qq(-260), vrest: qq(-260), vthr: qq(-208), vreset: qq(-260),
          ex: 64'd0, inh: 64'd0, tau: qq(1), dt: 4'b1000, rin: 8'd0, rper: 8'd5};
    run_directed("rest", b, qq(-260), 8'd0, 1'b0);
    b.id = 11'd8; b.vmem = qq(-220);
    run_directed("leak", b, qq(-225), 8'd0, 1'b0);
    b = '{id: 11'd9, vmem: qq(-212), vrest: qq(-212), vthr: qq(-208), vreset: qq(-260),
          ex: qq(6), inh: qq(-1), tau: qq(1), dt: 4'b1000, rin: 8'd0, rper: 8'd5};
    run_directed("spike", b, qq(-260), 8'd5, 1'b1);
    b.rin = 8'd3;
    run_directed("refrac", b, qq(-260), 8'd2, 1'b0);
    b = '{id: 11'd10, vmem: MAXV, vrest: MAXV, vthr: MAXV, vreset: qq(-260),
          ex: MAXV, inh: 64'd0, tau: qq(1), dt: 4'b1000, rin: 8'd0, rper: 8'd9};
    run_directed("sat_pos", b, qq(-260), 8'd9, 1'b1);
    b = '{id: 11'd11, vmem: MINV, vrest: MINV, vthr: qq(-208), vreset: qq(-260),
          ex: MINV, inh: MINV, tau: qq(1), dt: 4'b1000, rin: 8'd0, rper: 8'd9};
    run_directed("sat_neg", b, MINV, 8'd0, 1'b0);

    // 10-beat stream with out_ready pattern 1,0,0
    sent = 0; cur = rand_beat(); drive(cur);
    for (int k = 0; k < 300 && (sent < 10 || occ > 0); k++) begin
      in_valid  = (sent < 10);
      out_ready = (k % 3 == 0);
      cycle();
      if (acc_now) begin sent++; cur = rand_beat(); drive(cur); end
    end
    check_eq("stream_sent", 64'(sent), 64'(10));
    check_eq("stream_drain", 64'(occ), 64'(0));

    // Random traffic
    sent = 0; cur = rand_beat(); drive(cur);
    for (int k = 0; k < 3000 && (sent < 400 || occ > 0); k++) begin
      in_valid  = (sent < 400) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      if (acc_now) begin sent++; cur = rand_beat(); drive(cur); end
    end
    check_eq("random_sent", 64'(sent), 64'(400));
    check_eq("random_drain", 64'(occ), 64'(0));

    // Reset with three beats in flight
    out_ready = 1'b0; in_valid = 1'b1; cur = rand_beat(); drive(cur);
    for (int k = 0; k < 20 && occ < 3; k++) begin
      cycle();
      if (acc_now) begin cur = rand_beat(); drive(cur); end
    end
    check_eq("fill_occ", 64'(occ), 64'(3));
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete(); acc_q.delete(); occ = 0; stall_held = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) cycle();
    b = '{id: 11'd12, vmem: qq(-260), vrest: qq(-260), vthr: qq(-208), vreset: qq(-260),
          ex: 64'd0, inh: 64'd0, tau: qq(1), dt: 4'b1000, rin: 8'd0, rper: 8'd5};
    run_directed("post_reset", b, qq(-260), 8'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
